// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared types and constants for the tile ping-pong scheduler.
//   buf_state_e  : per-buffer state (FREE=0, FILL=1, FULL=2, FLUSH=3)
//   TILE_COUNT   : number of tile ids on the panel (ids 0x00..0x4F)
//   TILE_ID_W    : tile id width
//   TILE_ADDR_W  : pixel address width inside one tile buffer ({x[1:0], y[7:0]})
//   PIXEL_W      : pixel data width
// ---------------------------------------------------------------------------
package tile_pkg;

    typedef enum logic [1:0] {
        BUF_FREE  = 2'd0,
        BUF_FILL  = 2'd1,
        BUF_FULL  = 2'd2,
        BUF_FLUSH = 2'd3
    } buf_state_e;

    localparam int TILE_COUNT  = 80;
    localparam int TILE_ID_W   = $clog2(TILE_COUNT);
    localparam int TILE_ADDR_W = 10;
    localparam int PIXEL_W     = 16;

endpackage

// File: rtl/tile_buffer_sched_if.sv
// ---------------------------------------------------------------------------
// tile_buffer_sched_if
// Bundles the producer write stream, the tile RAM write port and the flush
// handshake of the tile scheduler.
//   master : producer / flush unit side (drives draw_*, flush_done)
//   slave  : scheduler side (drives draw_ready, buf_*, flush_*, err_overrun)
// ---------------------------------------------------------------------------
interface tile_buffer_sched_if
    import tile_pkg::*;
#(
    parameter int ID_W = TILE_ID_W
) ();

    logic [PIXEL_W-1:0]     draw_wrdata;
    logic [TILE_ADDR_W-1:0] draw_wraddr;
    logic                   draw_we;
    logic [ID_W-1:0]        draw_id;
    logic                   draw_next;
    logic                   draw_ready;
    logic [PIXEL_W-1:0]     buf_wrdata;
    logic [TILE_ADDR_W-1:0] buf_wraddr;
    logic [1:0]             buf_we;
    logic                   flush_start;
    logic                   flush_buf;
    logic [ID_W-1:0]        flush_id;
    logic                   flush_done;
    logic                   err_overrun;

    modport master (
        output draw_wrdata, draw_wraddr, draw_we, draw_id, draw_next, flush_done,
        input  draw_ready, buf_wrdata, buf_wraddr, buf_we,
        input  flush_start, flush_buf, flush_id, err_overrun
    );

    modport slave (
        input  draw_wrdata, draw_wraddr, draw_we, draw_id, draw_next, flush_done,
        output draw_ready, buf_wrdata, buf_wraddr, buf_we,
        output flush_start, flush_buf, flush_id, err_overrun
    );

endinterface

// File: rtl/tile_buf_state.sv
// ---------------------------------------------------------------------------
// tile_buf_state
// State and tile id of one tile buffer. Each request input only acts from
// the one state it is legal in, so the top may raise requests freely.
//   clk, rst     : clock, synchronous active-high reset
//   i_set_fill   : FREE  -> FILL
//   i_set_full   : FILL  -> FULL, captures i_full_id
//   i_set_flush  : FULL  -> FLUSH
//   i_set_free   : FLUSH -> FREE
//   o_state      : current state
//   o_id         : tile id stored at the last FULL transition
// ---------------------------------------------------------------------------
module tile_buf_state
    import tile_pkg::*;
#(
    parameter buf_state_e RST_STATE = BUF_FREE,
    parameter int         ID_W      = TILE_ID_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_set_fill,
    input  logic            i_set_full,
    input  logic [ID_W-1:0] i_full_id,
    input  logic            i_set_flush,
    input  logic            i_set_free,
    output buf_state_e      o_state,
    output logic [ID_W-1:0] o_id
);

    buf_state_e      r_state;
    logic [ID_W-1:0] r_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_STATE;
            r_id    <= '0;
        end else begin
            case (r_state)
                BUF_FREE:  if (i_set_fill)  r_state <= BUF_FILL;
                BUF_FILL:  if (i_set_full) begin
                               r_state <= BUF_FULL;
                               r_id    <= i_full_id;
                           end
                BUF_FULL:  if (i_set_flush) r_state <= BUF_FLUSH;
                BUF_FLUSH: if (i_set_free)  r_state <= BUF_FREE;
                default:                    r_state <= BUF_FREE;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_id    = r_id;

endmodule

// File: rtl/tile_buffer_sched.sv
// ---------------------------------------------------------------------------
// tile_buffer_sched
// Ping-pong scheduler between the tile producer and the LCD tile flush unit.
// Routes producer writes to the buffer being filled, closes a tile WR_LAT
// cycles after draw_next, hands full buffers to the flush unit in completion
// order and pulses draw_ready when the producer may start a new tile.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : producer stream, tile RAM write port, flush handshake
//   stall_cycles   : (TILE_SCHED_STATS_EN only) cycles stalled waiting to switch
//   tiles_flushed  : (TILE_SCHED_STATS_EN only) accepted flush_done count
// Optional build macro: TILE_SCHED_STATS_EN adds the two statistics outputs.
// ---------------------------------------------------------------------------
module tile_buffer_sched
    import tile_pkg::*;
#(
    parameter int WR_LAT = 3,
    parameter int ID_W   = TILE_ID_W
) (
    input  logic                clk,
    input  logic                rst,
    tile_buffer_sched_if.slave  bus
`ifdef TILE_SCHED_STATS_EN
    ,
    output logic [15:0]         stall_cycles,
    output logic [15:0]         tiles_flushed
`endif
);

    localparam int CNT_W = 3;

    buf_state_e             w_state [2];
    logic [ID_W-1:0]        w_id    [2];
    logic [1:0]             w_set_fill, w_set_full, w_set_flush, w_set_free;

    logic                   r_wr_sel, r_rd_sel;
    logic                   r_close_pend;
    logic [CNT_W-1:0]       r_close_cnt;
    logic [ID_W-1:0]        r_pend_id;
    logic                   r_draw_ready;
    logic [PIXEL_W-1:0]     r_buf_wrdata;
    logic [TILE_ADDR_W-1:0] r_buf_wraddr;
    logic [1:0]             r_buf_we;
    logic                   r_flush_start, r_flush_buf;
    logic [ID_W-1:0]        r_flush_id;
    logic                   r_err_overrun;

    buf_state_e             w_wr_state, w_oth_state, w_rd_state;
    logic [ID_W-1:0]        w_close_id;
    logic                   w_close_fire, w_any_flush, w_switch, w_flush_go, w_flush_ack;

    assign w_wr_state  = w_state[r_wr_sel];
    assign w_oth_state = w_state[~r_wr_sel];
    assign w_rd_state  = w_state[r_rd_sel];
    assign w_any_flush = (w_state[0] == BUF_FLUSH) || (w_state[1] == BUF_FLUSH);
    assign w_switch    = (w_wr_state == BUF_FULL) && (w_oth_state == BUF_FREE);
    assign w_flush_go  = !w_any_flush && (w_rd_state == BUF_FULL);
    assign w_flush_ack = bus.flush_done && (w_rd_state == BUF_FLUSH);

    // With no write pipeline the tile closes in the draw_next cycle itself;
    // otherwise it closes in the cycle the counter steps from 1 to 0, so the
    // producer's last in-flight write still sees the buffer in FILL.
    generate
        if (WR_LAT == 0) begin : g_close_now
            assign w_close_fire = bus.draw_next;
            assign w_close_id   = bus.draw_id;
        end else begin : g_close_cnt
            assign w_close_fire = r_close_pend && (r_close_cnt == CNT_W'(1));
            assign w_close_id   = r_pend_id;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            logic w_is_wr, w_is_rd;
            assign w_is_wr         = (r_wr_sel == (gi != 0));
            assign w_is_rd         = (r_rd_sel == (gi != 0));
            assign w_set_fill[gi]  = w_switch && !w_is_wr;
            assign w_set_full[gi]  = w_close_fire && w_is_wr;
            assign w_set_flush[gi] = w_flush_go && w_is_rd;
            assign w_set_free[gi]  = w_flush_ack && w_is_rd;

            tile_buf_state #(
                .RST_STATE (buf_state_e'((gi == 0) ? BUF_FILL : BUF_FREE)),
                .ID_W      (ID_W)
            ) u_state (
                .clk         (clk),
                .rst         (rst),
                .i_set_fill  (w_set_fill[gi]),
                .i_set_full  (w_set_full[gi]),
                .i_full_id   (w_close_id),
                .i_set_flush (w_set_flush[gi]),
                .i_set_free  (w_set_free[gi]),
                .o_state     (w_state[gi]),
                .o_id        (w_id[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_sel      <= 1'b0;
            r_rd_sel      <= 1'b0;
            r_close_pend  <= 1'b0;
            r_close_cnt   <= '0;
            r_pend_id     <= '0;
            r_draw_ready  <= 1'b0;
            r_buf_wrdata  <= '0;
            r_buf_wraddr  <= '0;
            r_buf_we      <= '0;
            r_flush_start <= 1'b0;
            r_flush_buf   <= 1'b0;
            r_flush_id    <= '0;
            r_err_overrun <= 1'b0;
        end else begin
            r_buf_wrdata <= bus.draw_wrdata;
            r_buf_wraddr <= bus.draw_wraddr;
            r_buf_we     <= '0;
            if (bus.draw_we) begin
                if (w_wr_state == BUF_FILL) r_buf_we[r_wr_sel] <= 1'b1;
                else                        r_err_overrun      <= 1'b1;
            end

            if (WR_LAT != 0) begin
                if (r_close_pend) begin
                    r_close_cnt <= r_close_cnt - CNT_W'(1);
                    if (r_close_cnt == CNT_W'(1)) r_close_pend <= 1'b0;
                end
                if (bus.draw_next) begin
                    if (r_close_pend) begin
                        r_err_overrun <= 1'b1;
                    end else begin
                        r_close_pend <= 1'b1;
                        r_close_cnt  <= CNT_W'(WR_LAT);
                        r_pend_id    <= bus.draw_id;
                    end
                end
            end

            r_draw_ready <= w_switch;
            if (w_switch) r_wr_sel <= ~r_wr_sel;

            r_flush_start <= w_flush_go;
            if (w_flush_go) begin
                r_flush_buf <= r_rd_sel;
                r_flush_id  <= w_id[r_rd_sel];
            end
            if (w_flush_ack) r_rd_sel <= ~r_rd_sel;
        end
    end

    assign bus.draw_ready  = r_draw_ready;
    assign bus.buf_wrdata  = r_buf_wrdata;
    assign bus.buf_wraddr  = r_buf_wraddr;
    assign bus.buf_we      = r_buf_we;
    assign bus.flush_start = r_flush_start;
    assign bus.flush_buf   = r_flush_buf;
    assign bus.flush_id    = r_flush_id;
    assign bus.err_overrun = r_err_overrun;

`ifdef TILE_SCHED_STATS_EN
    logic [15:0] r_stall_cycles, r_tiles_flushed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles  <= '0;
            r_tiles_flushed <= '0;
        end else begin
            if ((w_wr_state == BUF_FULL) && !w_switch && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (w_flush_ack)
                r_tiles_flushed <= r_tiles_flushed + 16'd1;
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign tiles_flushed = r_tiles_flushed;
`endif

endmodule

// File: tb/tb_tile_buffer_sched.sv
module tb_tile_buffer_sched;
    import tile_pkg::*;

    localparam int WR_LAT = 3;
    localparam int LAT    = WR_LAT + 1;   // draw_next edge -> draw_ready/flush_start edge

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_buffer_sched_if #(.ID_W(7)) bus ();

`ifdef TILE_SCHED_STATS_EN
    logic [15:0] stall_cycles, tiles_flushed;
`endif

    tile_buffer_sched #(.WR_LAT(WR_LAT), .ID_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef TILE_SCHED_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .tiles_flushed (tiles_flushed)
`endif
    );

    typedef struct packed {
        logic [1:0]  we;
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [6:0] id;
        int         nwr;
        logic       exp_buf;
    } tile_vec_t;

    wr_t        exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         ready_cnt = 0, ready_cyc = 0;
    int         fs_cnt = 0, fs_cyc = 0;
    logic       fs_buf = 1'b0;
    logic [6:0] fs_id  = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: event timestamps and write-port scoreboard.
    initial forever begin
        @(negedge clk);
        if (bus.draw_ready === 1'b1) begin
            ready_cnt++;
            ready_cyc = cyc;
        end
        if (bus.flush_start === 1'b1) begin
            fs_cnt++;
            fs_cyc = cyc;
            fs_buf = bus.flush_buf;
            fs_id  = bus.flush_id;
        end
        if (bus.buf_we !== 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'({bus.buf_we, bus.buf_wraddr, bus.buf_wrdata}), 32'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write", 32'({bus.buf_we, bus.buf_wraddr, bus.buf_wrdata}), 32'(e));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [9:0] a, input logic [15:0] d, input logic [1:0] m,
                      input bit nxt, input logic [6:0] id);
        bus.draw_we     = 1'b1;
        bus.draw_wraddr = a;
        bus.draw_wrdata = d;
        bus.draw_next   = nxt;
        bus.draw_id     = id;
        if (m != 2'b00) exp_q.push_back('{we: m, addr: a, data: d});
        tick();
        bus.draw_we   = 1'b0;
        bus.draw_next = 1'b0;
    endtask

    task automatic pulse_done();
        bus.flush_done = 1'b1;
        tick();
        bus.flush_done = 1'b0;
    endtask

    task automatic await_ready(input string nm, input int start, input int exp_c);
        for (int k = 0; k < 16 && ready_cnt == start; k++) begin
            @(negedge clk);
            #1;
        end
        if (ready_cnt == start) chk({nm, "_timeout"}, 32'(ready_cnt), 32'(start + 1));
        else                    chk(nm, 32'(ready_cyc), 32'(exp_c));
    endtask

    task automatic await_flush(input string nm, input int start, input int exp_c,
                               input logic eb, input logic [6:0] eid);
        for (int k = 0; k < 16 && fs_cnt == start; k++) begin
            @(negedge clk);
            #1;
        end
        if (fs_cnt == start) begin
            chk({nm, "_timeout"}, 32'(fs_cnt), 32'(start + 1));
        end else begin
            chk({nm, "_cyc"}, 32'(fs_cyc), 32'(exp_c));
            chk({nm, "_buf"}, 32'(fs_buf), 32'(eb));
            chk({nm, "_id"},  32'(fs_id),  32'(eid));
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_draw_ready"},  32'(bus.draw_ready),  32'h0);
        chk({nm, "_buf_we"},      32'(bus.buf_we),      32'h0);
        chk({nm, "_buf_wraddr"},  32'(bus.buf_wraddr),  32'h0);
        chk({nm, "_buf_wrdata"},  32'(bus.buf_wrdata),  32'h0);
        chk({nm, "_flush_start"}, 32'(bus.flush_start), 32'h0);
        chk({nm, "_flush_buf"},   32'(bus.flush_buf),   32'h0);
        chk({nm, "_flush_id"},    32'(bus.flush_id),    32'h0);
        chk({nm, "_err"},         32'(bus.err_overrun), 32'h0);
    endtask

    initial begin
        tile_vec_t tv[4];
        int rs, fsn, c0, d;

        tv[0] = '{id: 7'h12, nwr: 4, exp_buf: 1'b0};
        tv[1] = '{id: 7'h13, nwr: 5, exp_buf: 1'b1};
        tv[2] = '{id: 7'h4F, nwr: 3, exp_buf: 1'b0};
        tv[3] = '{id: 7'h00, nwr: 6, exp_buf: 1'b1};

        bus.draw_we = 1'b0; bus.draw_next = 1'b0; bus.draw_id = '0;
        bus.draw_wraddr = '0; bus.draw_wrdata = '0; bus.flush_done = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // flush_done with nothing flushing is ignored
        rs = ready_cnt; fsn = fs_cnt;
        pulse_done();
        repeat (3) tick();
        chk("spurious_done_ready", 32'(ready_cnt), 32'(rs));
        chk("spurious_done_flush", 32'(fs_cnt), 32'(fsn));
        $display("spurious flush_done: ready=%0d flush_start=%0d", ready_cnt - rs, fs_cnt - fsn);

        // Single full tile into buf0, id 0x05
        rs = ready_cnt; fsn = fs_cnt;
        for (int i = 0; i < 1024; i++)
            px(10'(i), 16'(i) ^ 16'hA5A5, 2'b01, i == 1023, 7'h05);
        c0 = cyc;
        await_ready("t1_ready", rs, c0 + LAT);
        await_flush("t1_flush", fsn, c0 + LAT, 1'b0, 7'h05);
        chk("t1_err", 32'(bus.err_overrun), 32'h0);
        $display("tile 0x05: 1024 writes, ready@%0d flush buf=%0d id=%0h", ready_cyc - c0, fs_buf, fs_id);

        // Stall: buf0 still flushing while tile 0x06 completes in buf1
        rs = ready_cnt; fsn = fs_cnt;
        for (int i = 0; i < 16; i++)
            px(10'(i), 16'h1000 + 16'(i), 2'b10, i == 15, 7'h06);
        repeat (8) tick();
        chk("stall_no_ready", 32'(ready_cnt), 32'(rs));
        chk("stall_no_flush", 32'(fs_cnt), 32'(fsn));
        pulse_done();
        d = cyc;
        await_ready("stall_ready", rs, d + 1);
        await_flush("stall_flush", fsn, d + 1, 1'b1, 7'h06);
        $display("tile 0x06: stalled, released ready@+%0d flush buf=%0d", ready_cyc - d, fs_buf);

        // Late writes 1..3 cycles after draw_next land on the closing buffer (buf0)
        rs = ready_cnt; fsn = fs_cnt;
        for (int i = 0; i < 8; i++)
            px(10'(i), 16'h2000 + 16'(i), 2'b01, i == 7, 7'h07);
        for (int j = 1; j <= WR_LAT; j++)
            px(10'(100 + j), 16'h2100 + 16'(j), 2'b01, 1'b0, 7'h00);
        chk("late_err", 32'(bus.err_overrun), 32'h0);
        $display("tile 0x07: %0d late writes, err=%0d", WR_LAT, bus.err_overrun);

        // Overrun: buf0 FULL, buf1 FLUSH -> write dropped, sticky error
        tick();
        px(10'd300, 16'hDEAD, 2'b00, 1'b0, 7'h00);
        chk("ovr_buf_we", 32'(bus.buf_we), 32'h0);
        chk("ovr_err", 32'(bus.err_overrun), 32'h1);
        repeat (4) tick();
        chk("ovr_err_sticky", 32'(bus.err_overrun), 32'h1);
        chk("ovr_no_ready", 32'(ready_cnt), 32'(rs));
        pulse_done();
        d = cyc;
        await_ready("ovr_ready", rs, d + 1);
        await_flush("ovr_flush", fsn, d + 1, 1'b0, 7'h07);
        $display("overrun: write dropped, err=%0d", bus.err_overrun);

        // Simultaneous: tile 0x4F closes in buf1 on the flush_done cycle of buf0
        rs = ready_cnt; fsn = fs_cnt;
        for (int i = 0; i < 8; i++)
            px(10'(i), 16'h3000 + 16'(i), 2'b10, i == 7, 7'h4F);
        c0 = cyc;
        repeat (WR_LAT - 1) tick();
        pulse_done();
        await_ready("simul_ready", rs, c0 + LAT);
        await_flush("simul_flush", fsn, c0 + LAT, 1'b1, 7'h4F);
        $display("simultaneous close+done: ready@%0d flush buf=%0d id=%0h", ready_cyc - c0, fs_buf, fs_id);

        // Reset while buf1 is flushing
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        fsn = fs_cnt;
        repeat (5) tick();
        chk("midrst_no_reissue", 32'(fs_cnt), 32'(fsn));
        $display("reset mid-flush: outputs cleared");

        // Table of tiles after reset, each flushed promptly; buffers alternate from 0
        for (int t = 0; t < 4; t++) begin
            rs = ready_cnt; fsn = fs_cnt;
            for (int i = 0; i < tv[t].nwr; i++)
                px(10'(i * 7), 16'h4000 + 16'(t * 16 + i), tv[t].exp_buf ? 2'b10 : 2'b01,
                   i == tv[t].nwr - 1, tv[t].id);
            c0 = cyc;
            await_ready($sformatf("tbl%0d_ready", t), rs, c0 + LAT);
            await_flush($sformatf("tbl%0d_flush", t), fsn, c0 + LAT, tv[t].exp_buf, tv[t].id);
            pulse_done();
            $display("table tile %0d: id=%0h buf=%0d", t, fs_id, fs_buf);
        end

`ifdef TILE_SCHED_STATS_EN
        chk("stats_tiles_flushed", 32'(tiles_flushed), 32'd4);
        chk("stats_stall_cycles", 32'(stall_cycles), 32'd0);
`endif

        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_buffer_sched.md
Name: tile_buffer_sched

Overview:
Ping-pong scheduler between the tile producer (character overlay / renderer write stream) and the LCD tile flush unit.
- Owns two 80x… tile buffers (1024 x 16 bit each, addressed {x[1:0], y[7:0]}); routes producer writes to the buffer being filled.
- Hands completed tiles to the flush unit, and raises draw_ready so the producer may start its next tile.
- Sits between the drawing blocks and the tile RAMs / LCD streamer.

Parameters:
WR_LAT, 3, cycles from draw_next to the producer's last draw_we (producer write pipeline depth); range 0..7
ID_W, 7, tile id width (tile ids 0x00..0x4F)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
draw_wrdata  in  16  producer pixel data
draw_wraddr  in  10  producer pixel address
draw_we  in  1  producer write strobe
draw_id  in  ID_W  id of tile currently being drawn; valid in the cycle draw_next is high
draw_next  in  1  one-cycle pulse: producer has issued the last pixel of the current tile
draw_ready  out  1  one-cycle pulse: producer may begin the next tile
buf_wrdata  out  16  registered copy of draw_wrdata
buf_wraddr  out  10  registered copy of draw_wraddr
buf_we  out  2  per-buffer write enable, at most one bit high
flush_start  out  1  one-cycle pulse: start streaming buffer flush_buf
flush_buf  out  1  buffer index to flush; stable while flushing
flush_id  out  ID_W  tile id of the buffer being flushed; stable while flushing
flush_done  in  1  one-cycle pulse from flush unit: buffer fully read
err_overrun  out  1  sticky: write attempted with no buffer in FILL

Behaviour:
- Per-buffer state, 2 bits: FREE, FILL, FULL, FLUSH. Stored per buffer: state and tile id. Pointers: wr_sel (buffer being filled) and rd_sel (next buffer to flush).
- Reset values: buf0=FILL, buf1=FREE, wr_sel=0, rd_sel=0, ids=0. All outputs are 0: draw_ready, buf_we, buf_wraddr, buf_wrdata, flush_start, flush_buf, flush_id, err_overrun.
- Buf0 starts in FILL so the producer draws its first tile without waiting for draw_ready.
- Write path, 1-cycle latency:
  - buf_wrdata and buf_wraddr are registered from the producer.
  - buf_we[wr_sel] <= draw_we while buf[wr_sel]==FILL.
  - Otherwise the write is dropped and err_overrun is set (cleared only by rst).
- Close sequence:
  - On draw_next, latch draw_id into a pending-id register and load a close counter with WR_LAT.
  - When the counter reaches 0 (same cycle if WR_LAT=0), buf[wr_sel] goes FILL->FULL and takes the pending id.
  - Writes in the close window still go to wr_sel.
  - draw_next while a close is already pending: ignored; err_overrun is set.
- Switch:
  - When buf[wr_sel]==FULL and buf[~wr_sel]==FREE, set buf[~wr_sel]=FILL, toggle wr_sel, and pulse draw_ready for 1 cycle.
  - The switch is evaluated on registered state, so draw_ready is earliest 1 cycle after the FULL transition.
  - If the other buffer is FULL or FLUSH, the producer stalls (no draw_ready) until that buffer becomes FREE. draw_ready then follows 1 cycle after the FREE is registered.
- Flush:
  - When no buffer is in FLUSH and buf[rd_sel]==FULL, set buf[rd_sel]=FLUSH, drive flush_buf=rd_sel and flush_id=id[rd_sel], and pulse flush_start.
  - On flush_done: buf[rd_sel] goes FLUSH->FREE and rd_sel toggles.
  - flush_done with no buffer in FLUSH is ignored.
- Simultaneous events: a FULL transition on one buffer and flush_done on the other in the same cycle are both applied. The switch then occurs the next cycle.
- Ordering: tiles are flushed strictly in completion order (rd_sel alternates). Tile id wrap (0x4F->0x00) needs no special handling.
- Reset mid-operation: immediately return to reset state. In-flight writes are discarded and flush_start is not re-issued. The flush unit shares rst.

Optional Feature:
TILE_SCHED_STATS_EN
- With the macro: add outputs stall_cycles (16 bit) and tiles_flushed (16 bit), both reset to 0.
  - stall_cycles increments every cycle the wr_sel buffer is FULL awaiting a switch; saturates at 0xFFFF.
  - tiles_flushed increments on each accepted flush_done; wraps.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package tile_pkg holds:
  - buffer-state enum (FREE=0, FILL=1, FULL=2, FLUSH=3);
  - TILE_COUNT=80, TILE_ID_W=7, TILE_ADDR_W=10, PIXEL_W=16.
- One natural sub-module: tile_buf_state, a per-buffer state and id register with FULL/FLUSH/FREE/FILL transition inputs, instantiated twice.
- Close counter, pointers and write routing stay in the top.

Test Plan:
- Single tile: after reset, draw_we x1024 then draw_next with draw_id=0x05, WR_LAT=3.
  - Required: buf_we[0] on all 1024 writes; 3 cycles later buf0 FULL; next cycle draw_ready pulse and buf1 FILL.
  - Required: flush_start with flush_buf=0, flush_id=0x05.
- Stall: hold flush_done low and complete two tiles.
  - Required: no draw_ready after the second draw_next.
  - Required: one flush_done pulse -> buf0 FREE, draw_ready exactly 1 cycle later, wr_sel=0.
- Late writes: draw_we asserted 1, 2 and 3 cycles after draw_next (WR_LAT=3).
  - Required: all land on the closing buffer; err_overrun stays 0.
- Overrun: draw_we while both buffers are FULL/FLUSH -> write dropped, err_overrun=1 until rst.
- Simultaneous: draw_next close completes on the same cycle as flush_done for the other buffer -> both applied; draw_ready next cycle.
- Reset mid-flush: rst during FLUSH -> all outputs 0, buf0 FILL; a subsequent tile is flushed with flush_buf=0.
